// File: rtl/register_slice_pipe.sv
// register_slice_pipe: DEPTH chained skid-buffer stages with a valid/ready stream on each side.
// Optional occupancy counter output when REGISTER_SLICE_PIPE_COUNT_EN is defined.
module register_slice_pipe #(
  parameter int                WIDTH     = 8,
  parameter int                DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef REGISTER_SLICE_PIPE_COUNT_EN
  ,
  output logic [$clog2(2*DEPTH+1)-1:0] occupancy
`endif
);

  // Handshake: a beat moves across any link when its valid and ready are both high at
  // posedge clk. Valid never waits on ready; ready comes straight from a register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  logic [DEPTH:0]   link_valid;
  logic [DEPTH:0]   link_ready;
  logic [WIDTH-1:0] link_data [DEPTH+1];

  assign link_valid[0]   = s_valid;
  assign link_data[0]    = s_data;
  assign link_ready[DEPTH] = m_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    stage_state_t     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_xfer;
    logic             out_take;

    assign in_xfer  = link_valid[k] && (state_q != FULL);
    assign out_take = (state_q != EMPTY) && link_ready[k+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= EMPTY;
        main_q  <= RESET_VAL;
        skid_q  <= RESET_VAL;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end

    // Flush only empties the stage; data registers keep their stale contents.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              state_d = ONE;
              main_d  = link_data[k];
            end
          end
          ONE: begin
            if (in_xfer && out_take) begin
              main_d = link_data[k];
            end else if (in_xfer) begin
              state_d = FULL;
              skid_d  = link_data[k];
            end else if (out_take) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (out_take) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    assign link_ready[k]   = (state_q != FULL);
    assign link_valid[k+1] = (state_q != EMPTY);
    assign link_data[k+1]  = main_q;
  end

  assign s_ready = link_ready[0] && !rst;
  assign m_valid = link_valid[DEPTH];
  assign m_data  = link_data[DEPTH];

`ifdef REGISTER_SLICE_PIPE_COUNT_EN
  localparam int CW = $clog2(2*DEPTH+1);
  logic s_fire;
  logic m_fire;

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (s_fire && !m_fire) begin
      occupancy <= occupancy + CW'(1);
    end else if (m_fire && !s_fire) begin
      occupancy <= occupancy - CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_register_slice_pipe.sv
// Bench for register_slice_pipe: three instances (DEPTH 1, 2, 4); directed tests on DEPTH 2,
// randomized traffic on all three, each checked by its own expected-beat queue.
module tb_register_slice_pipe;

  localparam logic [7:0] RST_VAL = 8'hC3;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [2:0]      s_valid;
  logic [2:0]      s_ready;
  logic [2:0][7:0] s_data;
  logic [2:0]      m_valid;
  logic [2:0]      m_ready;
  logic [2:0][7:0] m_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : 4;
`ifdef REGISTER_SLICE_PIPE_COUNT_EN
    logic [$clog2(2*D+1)-1:0] occupancy;
`endif
    logic [7:0] exp_q[$];
    logic       hold_prev;
    logic [7:0] data_prev;

    register_slice_pipe #(.WIDTH(8), .DEPTH(D), .RESET_VAL(RST_VAL)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .s_valid  (s_valid[g]),
      .s_ready  (s_ready[g]),
      .s_data   (s_data[g]),
      .m_valid  (m_valid[g]),
      .m_ready  (m_ready[g]),
      .m_data   (m_data[g])
`ifdef REGISTER_SLICE_PIPE_COUNT_EN
      ,
      .occupancy(occupancy)
`endif
    );

    // scoreboard: inputs are stable at negedge, so they show what the next edge transfers
    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        hold_prev <= 1'b0;
      end else begin
`ifdef REGISTER_SLICE_PIPE_COUNT_EN
        check("occupancy", 32'(occupancy), 32'(exp_q.size()));
`endif
        if (hold_prev) begin
          check("stable_valid", 32'(m_valid[g]), 32'd1);
          check("stable_data", 32'(m_data[g]), 32'(data_prev));
        end
        if (m_valid[g] && m_ready[g]) begin
          if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
          else check("sb_data", 32'(m_data[g]), 32'(exp_q.pop_front()));
        end
        if (flush) exp_q.delete();
        else if (s_valid[g] && s_ready[g]) exp_q.push_back(s_data[g]);
        hold_prev <= m_valid[g] && !m_ready[g] && !flush;
        data_prev <= m_data[g];
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input int i, input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      s_valid[i] = 1'b1;
      s_data[i]  = base + 8'(j);
      check("send_ready", 32'(s_ready[i]), 32'd1);
      tick();
    end
    s_valid[i] = 1'b0;
  endtask

  task automatic rand_run(input int i, input int n);
    int   sent = 0;
    int   cyc  = 0;
    logic fire;
    while (sent < n && cyc < 40000) begin
      if (!s_valid[i] && $urandom_range(0, 3) != 0) begin
        s_valid[i] = 1'b1;
        s_data[i]  = 8'($urandom_range(0, 255));
      end
      m_ready[i] = ($urandom_range(0, 3) != 0);
      fire = s_valid[i] && s_ready[i];
      tick();
      cyc++;
      if (fire) begin
        sent++;
        s_valid[i] = 1'b0;
      end
    end
    s_valid[i] = 1'b0;
    check("rand_sent", 32'(sent), 32'(n));
  endtask

  initial begin
    int   acc;
    int   w;
    logic fire;
    rst = 1'b1; flush = 1'b0;
    s_valid = '0; m_ready = '0; s_data = '0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_m_valid", 32'(m_valid[i]), 32'd0);
      check("rst_m_data", 32'(m_data[i]), 32'(RST_VAL));
      check("rst_s_ready", 32'(s_ready[i]), 32'd0);
    end
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check("rel_s_ready", 32'(s_ready[i]), 32'd1);
    tick();

    // stream 0x01..0x10 with no backpressure
    m_ready[1] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      s_valid[1] = 1'b1;
      s_data[1]  = 8'(k);
      check("stream_s_ready", 32'(s_ready[1]), 32'd1);
      tick();
      if (k == 1) check("stream_latency", 32'(m_valid[1]), 32'd0);
      else begin
        check("stream_m_valid", 32'(m_valid[1]), 32'd1);
        check("stream_m_data", 32'(m_data[1]), 32'(k - 1));
      end
    end
    s_valid[1] = 1'b0;
    tick();
    check("stream_last", 32'(m_data[1]), 32'h10);
    repeat (3) tick();
    m_ready[1] = 1'b0;

    // fill with backpressure
    acc = 0;
    s_valid[1] = 1'b1;
    s_data[1]  = 8'hA0;
    for (int c = 0; c < 8; c++) begin
      fire = s_ready[1];
      tick();
      if (fire) begin
        acc++;
        s_data[1] = 8'hA0 + 8'(acc);
      end
    end
    check("fill_count", 32'(acc), 32'd4);
    check("fill_s_ready", 32'(s_ready[1]), 32'd0);
    check("fill_m_valid", 32'(m_valid[1]), 32'd1);
    check("fill_m_data", 32'(m_data[1]), 32'hA0);
`ifdef REGISTER_SLICE_PIPE_COUNT_EN
    check("fill_occupancy", 32'(g_inst[1].occupancy), 32'd4);
`endif

    // drain
    s_valid[1] = 1'b0;
    m_ready[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("drain_m_valid", 32'(m_valid[1]), 32'd1);
      check("drain_m_data", 32'(m_data[1]), 32'(8'hA0 + 8'(j)));
      tick();
      if (j == 1) check("drain_s_ready", 32'(s_ready[1]), 32'd1);
    end
    check("drain_empty", 32'(m_valid[1]), 32'd0);
    m_ready[1] = 1'b0;

    // flush with 3 beats held and a 0x55 offered in the same cycle
    send_beats(1, 8'h11, 3);
    s_valid[1] = 1'b1;
    s_data[1]  = 8'h55;
    flush      = 1'b1;
    tick();
    flush      = 1'b0;
    s_valid[1] = 1'b0;
    check("flush_m_valid", 32'(m_valid[1]), 32'd0);
`ifdef REGISTER_SLICE_PIPE_COUNT_EN
    check("flush_occupancy", 32'(g_inst[1].occupancy), 32'd0);
`endif
    m_ready[1] = 1'b1;
    repeat (4) begin
      tick();
      check("flush_quiet", 32'(m_valid[1]), 32'd0);
      check("flush_no_55", 32'(m_data[1] == 8'h55), 32'd0);
    end
    m_ready[1] = 1'b0;

    // asynchronous reset with 3 beats held
    send_beats(1, 8'h21, 3);
    #2 rst = 1'b1;
    #1;
    check("arst_m_valid", 32'(m_valid[1]), 32'd0);
    check("arst_m_data", 32'(m_data[1]), 32'(RST_VAL));
    check("arst_s_ready", 32'(s_ready[1]), 32'd0);
    tick();
    check("arst_hold_s_ready", 32'(s_ready[1]), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("arst_rel_s_ready", 32'(s_ready[1]), 32'd1);
    m_ready[1] = 1'b1;
    repeat (6) begin
      tick();
      check("arst_no_old", 32'(m_valid[1]), 32'd0);
    end

    // random traffic on all depths
    fork
      rand_run(0, 10000);
      rand_run(1, 10000);
      rand_run(2, 10000);
    join
    m_ready = 3'b111;
    w = 0;
    while ((g_inst[0].exp_q.size() + g_inst[1].exp_q.size() + g_inst[2].exp_q.size()) != 0
           && w < 100) begin
      tick();
      w++;
    end
    tick();
    check("final_q0", 32'(g_inst[0].exp_q.size()), 32'd0);
    check("final_q1", 32'(g_inst[1].exp_q.size()), 32'd0);
    check("final_q2", 32'(g_inst[2].exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) check("final_m_valid", 32'(m_valid[i]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
